// File: rtl/vram_access_scheduler.sv
// Single-port VRAM arbiter: pixel fetches own the port during active video, CPU accesses fill idle slots.
// Build option: define VRAM_CPU_ACTIVE_EN to let CPU accesses use idle slots during active video too.
module vram_access_scheduler #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clkPixel,
    input  logic              reset,
    input  logic              blank,
    input  logic              frameDrawn,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_d,
    input  logic [DATA_W-1:0] vram_q,
    output logic              frame_irq,
    input  logic              irq_clr
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CPU_RD,
        CPU_WR,
        CPU_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_frame_d;
    logic              r_frame_irq;
    logic              w_fetch_go;
    logic              w_cpu_go;
    logic              w_cpu_slot;

`ifdef VRAM_CPU_ACTIVE_EN
    assign w_cpu_slot = blank | ~fetch_req;
`else
    assign w_cpu_slot = blank;
`endif

    // State register
    always_ff @(posedge clkPixel or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and grant decode; a fetch always beats a CPU request
    always_comb begin
        w_state_next = r_state;
        w_fetch_go   = 1'b0;
        w_cpu_go     = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_req && !blank) begin
                    w_fetch_go   = 1'b1;
                    w_state_next = FETCH;
                end else if (cpu_req && w_cpu_slot) begin
                    w_cpu_go     = 1'b1;
                    w_state_next = cpu_we ? CPU_WR : CPU_RD;
                end
            end
            FETCH: begin
                if (fetch_req && !blank) begin
                    w_fetch_go   = 1'b1;
                    w_state_next = FETCH;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CPU_RD:   w_state_next = CPU_DONE;
            CPU_WR:   w_state_next = CPU_DONE;
            CPU_DONE: w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Address goes out in the grant cycle so read data lands one cycle later
    always_comb begin
        w_addr = r_addr;
        if (reset) begin
            w_addr = '0;
        end else if (w_fetch_go) begin
            w_addr = fetch_addr;
        end else if (w_cpu_go) begin
            w_addr = cpu_addr;
        end
    end

    // Latched CPU transaction, captured read data and frame interrupt
    always_ff @(posedge clkPixel or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_frame_d   <= 1'b0;
            r_frame_irq <= 1'b0;
        end else begin
            r_addr    <= w_addr;
            r_frame_d <= frameDrawn;
            if (w_cpu_go) begin
                r_wdata <= cpu_wdata;
            end
            if (r_state == CPU_RD) begin
                r_rdata <= vram_q;
            end
            if (frameDrawn && !r_frame_d) begin
                r_frame_irq <= 1'b1;
            end else if (irq_clr) begin
                r_frame_irq <= 1'b0;
            end
        end
    end

    assign vram_addr   = w_addr;
    assign vram_we     = (r_state == CPU_WR);
    assign vram_d      = r_wdata;
    assign fetch_valid = (r_state == FETCH);
    assign cpu_ack     = (r_state == CPU_DONE);
    assign cpu_rdata   = r_rdata;
    assign frame_irq   = r_frame_irq;

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Bench for vram_access_scheduler: directed scenarios plus randomized traffic against a cycle-slot model.
module tb_vram_access_scheduler;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MEM_N  = 64;

    logic              clkPixel = 1'b0;
    logic              reset;
    logic              blank;
    logic              frameDrawn;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_d;
    logic [DATA_W-1:0] vram_q;
    logic              frame_irq;
    logic              irq_clr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vram_access_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clkPixel(clkPixel), .reset(reset), .blank(blank), .frameDrawn(frameDrawn),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_d(vram_d), .vram_q(vram_q), .frame_irq(frame_irq), .irq_clr(irq_clr)
    );

    always #5 clkPixel = ~clkPixel;

    // Synchronous-read VRAM seen by the DUT
    logic [DATA_W-1:0] vmem [MEM_N];
    always @(posedge clkPixel) begin
        if (vram_we) vmem[vram_addr[5:0]] <= vram_d;
        vram_q <= vmem[vram_addr[5:0]];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chka(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clkPixel);
        #1;
    endtask

    // Reference model: tracks which cycle each port owner was granted in and derives outputs from that
    int                m_fetch_cyc = -100;
    int                m_cpu_cyc   = -100;
    logic [ADDR_W-1:0] m_fetch_addr;
    logic [ADDR_W-1:0] m_cpu_addr;
    logic              m_cpu_we;
    logic [DATA_W-1:0] m_cpu_wdata;
    logic [DATA_W-1:0] m_fetch_data;
    logic [DATA_W-1:0] m_rdata;
    logic              m_irq     = 1'b0;
    logic              m_fd_prev = 1'b0;
    logic [DATA_W-1:0] ref_mem [MEM_N];

    initial begin : model
        logic busy, fetch_ok, cpu_ok, elig, exp_fv, exp_ack, exp_we;
        forever begin
            @(negedge clkPixel);
            if (reset) begin
                chk1("rst_fetch_valid", fetch_valid, 1'b0);
                chk1("rst_cpu_ack", cpu_ack, 1'b0);
                chk1("rst_vram_we", vram_we, 1'b0);
                chk1("rst_frame_irq", frame_irq, 1'b0);
                chka("rst_vram_addr", vram_addr, '0);
                chkd("rst_vram_d", vram_d, '0);
                chkd("rst_cpu_rdata", cpu_rdata, '0);
                m_fetch_cyc = -100;
                m_cpu_cyc   = -100;
                m_irq       = 1'b0;
                m_fd_prev   = 1'b0;
            end else begin
                exp_fv  = (m_fetch_cyc == cyc - 1);
                exp_ack = (m_cpu_cyc == cyc - 2);
                exp_we  = (m_cpu_cyc == cyc - 1) && m_cpu_we;
                busy    = (m_cpu_cyc == cyc - 1) || (m_cpu_cyc == cyc - 2);
                chk1("fetch_valid", fetch_valid, exp_fv);
                chk1("cpu_ack", cpu_ack, exp_ack);
                chk1("vram_we", vram_we, exp_we);
                chk1("frame_irq", frame_irq, m_irq);
                if (exp_fv) chkd("fetch_data", vram_q, m_fetch_data);
                if (exp_ack && !m_cpu_we) chkd("cpu_rdata", cpu_rdata, m_rdata);
                if (exp_we) begin
                    chkd("vram_d", vram_d, m_cpu_wdata);
                    ref_mem[m_cpu_addr[5:0]] = m_cpu_wdata;
                end
`ifdef VRAM_CPU_ACTIVE_EN
                elig = blank || !fetch_req;
`else
                elig = blank;
`endif
                fetch_ok = fetch_req && !blank && !busy;
                cpu_ok   = cpu_req && elig && !busy && !fetch_ok && (m_fetch_cyc != cyc - 1);
                if (fetch_ok) begin
                    chka("fetch_addr_out", vram_addr, fetch_addr);
                    m_fetch_cyc  = cyc;
                    m_fetch_addr = fetch_addr;
                    m_fetch_data = ref_mem[fetch_addr[5:0]];
                end else if (cpu_ok) begin
                    chka("cpu_addr_out", vram_addr, cpu_addr);
                    m_cpu_cyc   = cyc;
                    m_cpu_addr  = cpu_addr;
                    m_cpu_we    = cpu_we;
                    m_cpu_wdata = cpu_wdata;
                    m_rdata     = ref_mem[cpu_addr[5:0]];
                end else if (m_cpu_cyc == cyc - 1) begin
                    chka("cpu_addr_hold", vram_addr, m_cpu_addr);
                end
                if (frameDrawn && !m_fd_prev) m_irq = 1'b1;
                else if (irq_clr) m_irq = 1'b0;
                m_fd_prev = frameDrawn;
            end
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack_prev;
        reset = 1'b1; blank = 1'b0; frameDrawn = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; irq_clr = 1'b0;
        repeat (2) @(negedge clkPixel);
        tick(); reset = 1'b0; blank = 1'b1;

        // CPU write during blanking
        tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 32'hDEADBEEF;
        @(negedge clkPixel);
        chka("wr_grant_addr", vram_addr, 14'h0010);
        chk1("wr_grant_we", vram_we, 1'b0);
        tick(); @(negedge clkPixel);
        chk1("wr_strobe", vram_we, 1'b1);
        chka("wr_addr", vram_addr, 14'h0010);
        chkd("wr_data", vram_d, 32'hDEADBEEF);
        chk1("wr_no_early_ack", cpu_ack, 1'b0);
        tick(); @(negedge clkPixel);
        chk1("wr_ack", cpu_ack, 1'b1);
        chk1("wr_strobe_off", vram_we, 1'b0);
        tick(); cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clkPixel);
        chk1("wr_ack_single", cpu_ack, 1'b0);

        // CPU read back
        tick(); cpu_req = 1'b1; cpu_addr = 14'h0010;
        tick(); @(negedge clkPixel);
        chk1("rd_no_early_ack", cpu_ack, 1'b0);
        tick(); @(negedge clkPixel);
        chk1("rd_ack", cpu_ack, 1'b1);
        chkd("rd_data", cpu_rdata, 32'hDEADBEEF);
        tick(); cpu_req = 1'b0;

        // Fetch burst in active video with a competing CPU read
        for (int i = 0; i < 8; i++) begin
            tick(); blank = 1'b0; fetch_req = 1'b1; fetch_addr = 14'(i);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
            @(negedge clkPixel);
            chk1("burst_fetch_valid", fetch_valid, (i != 0));
            chk1("burst_cpu_blocked", cpu_ack, 1'b0);
        end
        tick(); fetch_req = 1'b0;
        @(negedge clkPixel);
        chk1("burst_last_valid", fetch_valid, 1'b1);
        chk1("burst_cpu_blocked_end", cpu_ack, 1'b0);
`ifdef VRAM_CPU_ACTIVE_EN
        for (int k = 1; k <= 3; k++) begin
            tick(); @(negedge clkPixel);
            chk1("active_cpu_ack", cpu_ack, (k == 3));
        end
`else
        for (int k = 1; k <= 6; k++) begin
            tick(); @(negedge clkPixel);
            chk1("active_cpu_waits", cpu_ack, 1'b0);
        end
        tick(); blank = 1'b1;
        @(negedge clkPixel); chk1("blank_cpu_grant", cpu_ack, 1'b0);
        tick(); @(negedge clkPixel); chk1("blank_cpu_access", cpu_ack, 1'b0);
        tick(); @(negedge clkPixel); chk1("blank_cpu_ack", cpu_ack, 1'b1);
`endif
        tick(); cpu_req = 1'b0;

        // Reset pulsed in the middle of a CPU write
        tick(); blank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0030; cpu_wdata = 32'h12345678;
        tick();
        chk1("rst_mid_we_before", vram_we, 1'b1);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        chk1("rst_mid_we_after", vram_we, 1'b0);
        chk1("rst_mid_ack", cpu_ack, 1'b0);
        tick();
        tick(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clkPixel);
            chk1("rst_mid_no_ack", cpu_ack, 1'b0);
            tick();
        end

        // Frame interrupt: set beats clear, then clear alone
        frameDrawn = 1'b0; irq_clr = 1'b0;
        tick(); frameDrawn = 1'b1; irq_clr = 1'b1;
        tick(); irq_clr = 1'b1;
        @(negedge clkPixel); chk1("irq_set_wins", frame_irq, 1'b1);
        tick(); irq_clr = 1'b0;
        @(negedge clkPixel); chk1("irq_cleared", frame_irq, 1'b0);
        tick(); frameDrawn = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            @(negedge clkPixel);
            ack_prev = cpu_ack;
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) reset = 1'b1;
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = 14'($urandom_range(0, 63));
            if (cpu_req && ack_prev) begin
                cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 14'($urandom_range(0, 63));
                cpu_wdata = $urandom();
            end
            if ($urandom_range(0, 7) == 0) frameDrawn = ~frameDrawn;
            irq_clr = ($urandom_range(0, 9) == 0);
        end

        tick(); reset = 1'b0; fetch_req = 1'b0; cpu_req = 1'b0;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_access_scheduler.md
VRAM_ACCESS_SCHEDULER -- requirements
Module: vram_access_scheduler

Interface
REQ-001 Parameter ADDR_W, default 14: VRAM word address width.
REQ-002 Parameter DATA_W, default 32: VRAM word width.
REQ-003 clkPixel  in  1  pixel clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 blank  in  1  high outside the active video area, from the video timing generator.
REQ-006 frameDrawn  in  1  high for the first ticks of each frame.
REQ-007 fetch_req  in  1  pixel pipeline requests a VRAM read this cycle.
REQ-008 fetch_addr  in  ADDR_W  pixel fetch address.
REQ-009 fetch_valid  out  1  fetch data valid on vram_q.
REQ-010 cpu_req  in  1  CPU access request; held until cpu_ack.
REQ-011 cpu_we  in  1  CPU access is a write when 1.
REQ-012 cpu_addr  in  ADDR_W  CPU address.
REQ-013 cpu_wdata  in  DATA_W  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack=1.
REQ-016 vram_addr  out  ADDR_W  VRAM port address.
REQ-017 vram_we  out  1  VRAM write strobe.
REQ-018 vram_d  out  DATA_W  VRAM write data.
REQ-019 vram_q  in  DATA_W  VRAM read data, one cycle after the address.
REQ-020 frame_irq  out  1  sticky frame interrupt.
REQ-021 irq_clr  in  1  clears frame_irq.

Function
REQ-022 The FSM SHALL have states IDLE, FETCH, CPU_RD, CPU_WR, CPU_DONE.
REQ-023 In IDLE, with fetch_req=1 and blank=0, it SHALL drive vram_addr=fetch_addr and enter FETCH. Fetch has absolute priority.
REQ-024 In FETCH, it SHALL assert fetch_valid for 1 cycle. It SHALL then accept a new fetch_req in that same cycle or return to IDLE, for back-to-back fetches at 1 per cycle.
REQ-025 In IDLE, with cpu_req=1 and the slot eligible (REQ-035), it SHALL latch cpu_addr, cpu_we and cpu_wdata, drive vram_addr, and enter CPU_WR if cpu_we=1, else CPU_RD.
REQ-026 CPU_WR: vram_we=1 for exactly 1 cycle with vram_d=latched data; next state CPU_DONE.
REQ-027 CPU_RD: address held 1 cycle; next state CPU_DONE.
REQ-028 CPU_DONE: cpu_ack=1 for 1 cycle. On a read, cpu_rdata SHALL be the registered vram_q. Next state IDLE.
REQ-029 Latency from cpu_req sampled in an eligible IDLE cycle to cpu_ack SHALL be exactly 2 cycles.
REQ-030 A CPU access, once started, SHALL complete even if blank falls mid-access. fetch_req arriving then SHALL be stalled, and fetch_valid SHALL follow 1 cycle after it is granted.
REQ-031 cpu_req and fetch_req in the same cycle with blank=0: the fetch wins and the CPU waits.
REQ-032 vram_we SHALL be 0 in every state except CPU_WR.
REQ-033 frame_irq SHALL set on the rising edge of frameDrawn and clear on irq_clr. If both occur in the same cycle, the set wins.

Reset
REQ-034 On reset=1 the block SHALL asynchronously enter IDLE. All outputs SHALL go to 0, including frame_irq, cpu_rdata, vram_addr and vram_d. Any in-flight CPU access is dropped without cpu_ack.

Configuration
REQ-035 Macro VRAM_CPU_ACTIVE_EN controls when a CPU slot is eligible:
- Defined: a CPU slot is eligible in any IDLE cycle with fetch_req=0, including during active video.
- Undefined: a CPU slot is eligible only when blank=1, and cpu_req during active video waits for blanking.

Verification
REQ-036 blank=1, cpu write addr 0x0010 data 0xDEADBEEF -> vram_we high for exactly 1 cycle with those values; cpu_ack 2 cycles after the request.
REQ-037 Then a CPU read of 0x0010 with the memory model returning 0xDEADBEEF -> cpu_rdata=0xDEADBEEF while cpu_ack=1.
REQ-038 blank=0, fetch_req held 8 cycles, addr 0..7 -> fetch_valid every cycle after the first, and a simultaneous cpu_req gets no ack until fetch_req drops.
REQ-039 blank=0, fetch_req=0, cpu_req=1 -> ack after 2 cycles if VRAM_CPU_ACTIVE_EN is defined; otherwise no ack until blank=1.
REQ-040 reset pulsed during CPU_WR -> vram_we=0 immediately, no cpu_ack, FSM in IDLE.
REQ-041 frameDrawn rising edge together with irq_clr -> frame_irq=1; irq_clr alone the next cycle -> frame_irq=0.
